// File: rtl/pmu_ahb_cmd_master_if.sv
// Command, response and AHB-Lite master signals of pmu_ahb_cmd_master.
// Modport master is the block's own view; modport slave is the view of whoever drives it.
interface pmu_ahb_cmd_master_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic                  cmd_write_i;
  logic [DATA_WIDTH-1:0] cmd_addr_i;
  logic [DATA_WIDTH-1:0] cmd_wdata_i;

  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [DATA_WIDTH-1:0] rsp_rdata_o;
  logic                  rsp_err_o;

  logic                  hsel_o;
  logic [DATA_WIDTH-1:0] haddr_o;
  logic                  hwrite_o;
  logic [1:0]            htrans_o;
  logic [2:0]            hsize_o;
  logic [2:0]            hburst_o;
  logic [3:0]            hprot_o;
  logic                  hmastlock_o;
  logic [DATA_WIDTH-1:0] hwdata_o;
  logic                  hready_i;
  logic [1:0]            hresp_i;
  logic [DATA_WIDTH-1:0] hrdata_i;

  modport master (
    input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i,
    output cmd_ready_o,
    output rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  rsp_ready_i,
    output hsel_o, haddr_o, hwrite_o, htrans_o, hsize_o, hburst_o, hprot_o,
    output hmastlock_o, hwdata_o,
    input  hready_i, hresp_i, hrdata_i
  );

  modport slave (
    output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i,
    input  cmd_ready_o,
    input  rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output rsp_ready_i,
    input  hsel_o, haddr_o, hwrite_o, htrans_o, hsize_o, hburst_o, hprot_o,
    input  hmastlock_o, hwdata_o,
    output hready_i, hresp_i, hrdata_i
  );
endinterface

// File: rtl/pmu_ahb_cmd_master.sv
// Queued single-word AHB-Lite master feeding the PMU AHB slave, plus its command FIFO.

// Generic synchronous FIFO, power-of-two depth.
// Latency: data pushed at an edge is visible at pop_dat after that edge.
// Backpressure: push_rdy is !full, derived only from the occupancy count.
module fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_vld,
  output logic             push_rdy,
  input  logic [WIDTH-1:0] push_dat,
  output logic             pop_vld,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] pop_dat
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    occ;
  logic             do_push;
  logic             do_pop;

  assign push_rdy = (occ != CW'(DEPTH));
  assign pop_vld  = (occ != '0);
  assign do_push  = push_vld & push_rdy;
  assign do_pop   = pop_rdy & pop_vld;
  assign pop_dat  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end
endmodule

// AHB-Lite master issuing one NONSEQ single-word transfer at a time from a command FIFO.
// Latency: command accepted at E0 -> address phase after E1, data after E2, response after E3.
// Backpressure: cmd_ready_o = FIFO not full; a held response stalls the FSM in RESP.
module pmu_ahb_cmd_master #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  pmu_ahb_cmd_master_if.master   bus
);
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef struct packed {
    logic                  write;
    logic [DATA_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } state_t;

  state_t                state;
  cmd_t                  push_cmd;
  cmd_t                  head;
  logic                  head_vld;
  logic                  pop;
  logic                  fifo_rdy;

  logic                  hsel_q;
  logic [DATA_WIDTH-1:0] haddr_q;
  logic                  hwrite_q;
  logic [1:0]            htrans_q;
  logic [DATA_WIDTH-1:0] hwdata_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_err_q;

  assign push_cmd = '{write: bus.cmd_write_i, addr: bus.cmd_addr_i, wdata: bus.cmd_wdata_i};
  // The head entry stays put until the address phase completes, so it is popped exactly then.
  assign pop      = (state == ST_ADDR) && bus.hready_i;

  fifo_sync #(
    .WIDTH ($bits(cmd_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk      (clk_i),
    .rst      (rst_i),
    .push_vld (bus.cmd_valid_i),
    .push_rdy (fifo_rdy),
    .push_dat (push_cmd),
    .pop_vld  (head_vld),
    .pop_rdy  (pop),
    .pop_dat  (head)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      hsel_q      <= 1'b0;
      haddr_q     <= '0;
      hwrite_q    <= 1'b0;
      htrans_q    <= HTRANS_IDLE;
      hwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (head_vld) begin
            state    <= ST_ADDR;
            hsel_q   <= 1'b1;
            htrans_q <= HTRANS_NONSEQ;
            haddr_q  <= {head.addr[DATA_WIDTH-1:2], 2'b00};
            hwrite_q <= head.write;
          end
        end
        ST_ADDR: begin
          if (bus.hready_i) begin
            state    <= ST_DATA;
            hsel_q   <= 1'b0;
            htrans_q <= HTRANS_IDLE;
            hwdata_q <= head.write ? head.wdata : '0;
          end
        end
        ST_DATA: begin
          // hwrite_q still holds the direction of the transfer in its data phase.
          if (bus.hready_i) begin
            state       <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= hwrite_q ? '0 : bus.hrdata_i;
            rsp_err_q   <= (bus.hresp_i != 2'b00);
            hwdata_q    <= '0;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready_i) begin
            state       <= ST_IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready_o = fifo_rdy;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_rdata_o = rsp_rdata_q;
  assign bus.rsp_err_o   = rsp_err_q;
  assign bus.hsel_o      = hsel_q;
  assign bus.haddr_o     = haddr_q;
  assign bus.hwrite_o    = hwrite_q;
  assign bus.htrans_o    = htrans_q;
  assign bus.hwdata_o    = hwdata_q;
  assign bus.hsize_o     = 3'b010;
  assign bus.hburst_o    = 3'b000;
  assign bus.hprot_o     = 4'b0011;
  assign bus.hmastlock_o = 1'b0;
endmodule

// File: tb/tb_pmu_ahb_cmd_master.sv
// Directed bench for pmu_ahb_cmd_master: write, read, backpressure, wait states, error, reset.
module tb_pmu_ahb_cmd_master;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pmu_ahb_cmd_master_if #(.DATA_WIDTH(32)) bus ();

  pmu_ahb_cmd_master #(
    .DATA_WIDTH (32),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Slave model: read data is the data-phase address XOR a key, unless a fixed value is forced.
  localparam logic [31:0] KEY = 32'h5A5A_0000;
  logic        fix_en;
  logic [31:0] fix_val;
  logic [31:0] cap_addr = '0;
  always @(posedge clk)
    if (bus.hsel_o && bus.htrans_o == 2'b10 && bus.hready_i) cap_addr <= bus.haddr_o;
  assign bus.hrdata_i = fix_en ? fix_val : (cap_addr ^ KEY);

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_write_i = w;
    bus.cmd_addr_i  = a;
    bus.cmd_wdata_i = d;
  endtask

  task automatic idle_cmd;
    bus.cmd_valid_i = 1'b0;
  endtask

  task automatic chk_reset_values(input string pfx);
    chk({pfx, "_cmd_rdy"},   32'(bus.cmd_ready_o), 32'd1);
    chk({pfx, "_rsp_vld"},   32'(bus.rsp_valid_o), 32'd0);
    chk({pfx, "_rsp_rdata"}, bus.rsp_rdata_o,      32'd0);
    chk({pfx, "_rsp_err"},   32'(bus.rsp_err_o),   32'd0);
    chk({pfx, "_hsel"},      32'(bus.hsel_o),      32'd0);
    chk({pfx, "_haddr"},     bus.haddr_o,          32'd0);
    chk({pfx, "_hwrite"},    32'(bus.hwrite_o),    32'd0);
    chk({pfx, "_htrans"},    32'(bus.htrans_o),    32'd0);
    chk({pfx, "_hwdata"},    bus.hwdata_o,         32'd0);
  endtask

  logic [31:0] bp_exp [5];
  int n_acc, n_rsp, n_bad;

  initial begin
    rst = 1'b1;
    fix_en = 1'b0;
    fix_val = '0;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_write_i = 1'b0;
    bus.cmd_addr_i  = '0;
    bus.cmd_wdata_i = '0;
    bus.rsp_ready_i = 1'b1;
    bus.hready_i    = 1'b1;
    bus.hresp_i     = 2'b00;
    tick();
    tick();
    chk_reset_values("rst");
    chk("rst_hsize",  32'(bus.hsize_o),     32'h2);
    chk("rst_hprot",  32'(bus.hprot_o),     32'h3);
    chk("rst_hburst", 32'(bus.hburst_o),    32'h0);
    chk("rst_hlock",  32'(bus.hmastlock_o), 32'h0);
    rst = 1'b0;
    tick();

    // Zero-wait write.
    drive_cmd(1'b1, 32'h8010_00AC, 32'hCAFE_CAFE);
    tick();
    idle_cmd();
    chk("wr_e0_hsel", 32'(bus.hsel_o), 32'd0);
    tick();
    chk("wr_hsel",   32'(bus.hsel_o),   32'd1);
    chk("wr_htrans", 32'(bus.htrans_o), 32'h2);
    chk("wr_haddr",  bus.haddr_o,       32'h8010_00AC);
    chk("wr_hwrite", 32'(bus.hwrite_o), 32'd1);
    tick();
    chk("wr_d_htrans", 32'(bus.htrans_o), 32'h0);
    chk("wr_d_hsel",   32'(bus.hsel_o),   32'd0);
    chk("wr_hwdata",   bus.hwdata_o,      32'hCAFE_CAFE);
    chk("wr_d_rspvld", 32'(bus.rsp_valid_o), 32'd0);
    tick();
    chk("wr_rsp_vld",   32'(bus.rsp_valid_o), 32'd1);
    chk("wr_rsp_err",   32'(bus.rsp_err_o),   32'd0);
    chk("wr_rsp_rdata", bus.rsp_rdata_o,      32'd0);
    tick();
    chk("wr_rsp_done", 32'(bus.rsp_valid_o), 32'd0);

    // Zero-wait read with a fixed slave value.
    fix_en = 1'b1;
    fix_val = 32'h1234_5678;
    drive_cmd(1'b0, 32'h8010_0004, 32'hFFFF_FFFF);
    tick();
    idle_cmd();
    tick();
    chk("rd_haddr",  bus.haddr_o,       32'h8010_0004);
    chk("rd_hwrite", 32'(bus.hwrite_o), 32'd0);
    tick();
    chk("rd_hwdata", bus.hwdata_o, 32'd0);
    tick();
    chk("rd_rsp_vld",   32'(bus.rsp_valid_o), 32'd1);
    chk("rd_rsp_rdata", bus.rsp_rdata_o,      32'h1234_5678);
    chk("rd_rsp_err",   32'(bus.rsp_err_o),   32'd0);
    tick();
    fix_en = 1'b0;

    // Response backpressure: 1 parked in RESP + 4 queued, 6th refused.
    bus.rsp_ready_i = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      logic [31:0] a;
      a = 32'h0000_0100 + 32'(4 * i) + 32'(i % 4);
      if (i < 5) bp_exp[i] = {a[31:2], 2'b00} ^ KEY;
      drive_cmd(1'b0, a, 32'd0);
      if (!bus.cmd_ready_o) break;
      tick();
      n_acc++;
    end
    idle_cmd();
    chk("bp_accepted", 32'(n_acc),           32'd5);
    chk("bp_cmd_rdy",  32'(bus.cmd_ready_o), 32'd0);
    chk("bp_rsp_vld",  32'(bus.rsp_valid_o), 32'd1);
    tick();
    tick();
    chk("bp_hold_vld",   32'(bus.rsp_valid_o), 32'd1);
    chk("bp_hold_rdata", bus.rsp_rdata_o,      bp_exp[0]);
    bus.rsp_ready_i = 1'b1;
    n_rsp = 0;
    for (int c = 0; c < 60; c++) begin
      if (bus.rsp_valid_o) begin
        if (n_rsp < 5) chk($sformatf("bp_rsp%0d", n_rsp), bus.rsp_rdata_o, bp_exp[n_rsp]);
        n_rsp++;
      end
      tick();
    end
    chk("bp_nrsp", 32'(n_rsp), 32'd5);

    // Wait states: 3 in ADDR, 2 in DATA.
    drive_cmd(1'b1, 32'h0000_0200, 32'h1111_2222);
    tick();
    idle_cmd();
    tick();
    bus.hready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("ws_htrans", 32'(bus.htrans_o), 32'h2);
      chk("ws_haddr",  bus.haddr_o,       32'h0000_0200);
      chk("ws_hsel",   32'(bus.hsel_o),   32'd1);
    end
    bus.hready_i = 1'b1;
    tick();
    chk("ws_hwdata", bus.hwdata_o, 32'h1111_2222);
    bus.hready_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("ws_dwait_vld",    32'(bus.rsp_valid_o), 32'd0);
      chk("ws_dwait_hwdata", bus.hwdata_o,         32'h1111_2222);
    end
    bus.hready_i = 1'b1;
    tick();
    chk("ws_rsp_vld", 32'(bus.rsp_valid_o), 32'd1);
    tick();

    // Error response, then a clean one.
    bus.hresp_i = 2'b01;
    drive_cmd(1'b0, 32'h0000_0013, 32'd0);
    tick();
    idle_cmd();
    tick();
    tick();
    tick();
    chk("err_vld", 32'(bus.rsp_valid_o), 32'd1);
    chk("err_err", 32'(bus.rsp_err_o),   32'd1);
    bus.hresp_i = 2'b00;
    tick();
    drive_cmd(1'b0, 32'h0000_0020, 32'd0);
    tick();
    idle_cmd();
    tick();
    tick();
    tick();
    chk("err2_vld",   32'(bus.rsp_valid_o), 32'd1);
    chk("err2_err",   32'(bus.rsp_err_o),   32'd0);
    chk("err2_rdata", bus.rsp_rdata_o,      32'h5A5A_0020);
    tick();

    // Reset during DATA with two commands queued.
    drive_cmd(1'b1, 32'h0000_0300, 32'd1);
    tick();
    drive_cmd(1'b1, 32'h0000_0304, 32'd2);
    tick();
    drive_cmd(1'b1, 32'h0000_0308, 32'd3);
    tick();
    idle_cmd();
    chk("rstm_pre_hwdata", bus.hwdata_o,     32'd1);
    chk("rstm_pre_hsel",   32'(bus.hsel_o),  32'd0);
    rst = 1'b1;
    tick();
    chk_reset_values("rstm");
    rst = 1'b0;
    n_bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.rsp_valid_o || bus.hsel_o) n_bad++;
      tick();
    end
    chk("rstm_quiet", 32'(n_bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
